// File: rtl/video_pattern_gen.sv
// Test-pattern video source: frame timing (vsync, dvalid) plus ramp/checker/constant data.
// Run/stop control only ever returns to idle on a frame boundary.
module video_pattern_gen #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CH      = 1,
  parameter int unsigned H_TOTAL = 1440,
  parameter int unsigned V_TOTAL = 600,
  parameter int unsigned IW      = 1280,
  parameter int unsigned IH      = 513,
  parameter int unsigned H_VLD_B = 0,
  parameter int unsigned V_VLD_B = 65,
  parameter int unsigned SYNC_B  = 5,
  parameter int unsigned SYNC_E  = 55,
  parameter int unsigned CW      = 11
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    const_val,
  output logic             test_vsync,
  output logic             test_dvalid,
  output logic [DW*CH-1:0] test_data,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam logic [CW-1:0] HLast   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HVld    = CW'(H_VLD_B);
  localparam logic [CW-1:0] VVld    = CW'(V_VLD_B);
  localparam logic [CW-1:0] SyncB   = CW'(SYNC_B);
  localparam logic [CW:0]   IwLen   = (CW+1)'(IW);
  localparam logic [CW:0]   IhLen   = (CW+1)'(IH);
  localparam logic [CW:0]   SyncLen = (CW+1)'(SYNC_E - SYNC_B + 1);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     h_q, h_d, v_q, v_d;
  logic [1:0]        mode_q, mode_eff;
  logic              counting, at_eol, at_eof, frame_first;
  logic              in_x, in_y, in_sync, active;
  logic [CW-1:0]     x, y, sync_rel;
  logic [DW*CH-1:0]  pix;

  always_comb begin
    counting = (state_q != StIdle);
    at_eol   = (h_q == HLast);
    at_eof   = at_eol && (v_q == VLast);
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun, StStop: begin
        // A stop request only takes effect once the last clock of the frame is counted.
        if (at_eof && !en) state_d = StIdle;
        else               state_d = en ? StRun : StStop;
        if (at_eol) begin
          h_d = '0;
          v_d = at_eof ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Offsets wrap to large values left of/above the window, so one compare covers both bounds.
  always_comb begin
    x           = h_q - HVld;
    y           = v_q - VVld;
    sync_rel    = v_q - SyncB;
    in_x        = ({1'b0, x} < IwLen);
    in_y        = ({1'b0, y} < IhLen);
    in_sync     = ({1'b0, sync_rel} < SyncLen);
    active      = counting && in_x && in_y;
    frame_first = counting && (h_q == '0) && (v_q == '0);
    mode_eff    = frame_first ? mode : mode_q;
    pix         = '0;
    for (int c = 0; c < int'(CH); c++) begin
      case (mode_eff)
        2'd0:    pix[c*DW +: DW] = DW'(32'(x) + 32'(c));
        2'd1:    pix[c*DW +: DW] = DW'(32'(y) + 32'(c));
        2'd2:    pix[c*DW +: DW] = {DW{x[3] ^ y[3]}};
        default: pix[c*DW +: DW] = const_val;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_l) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= 2'd0;
      test_vsync  <= 1'b1;
      test_dvalid <= 1'b0;
      test_data   <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      test_vsync  <= !(counting && in_sync);
      test_dvalid <= active;
      test_data   <= active ? pix : '0;
      frame_start <= frame_first;
      if (frame_first) begin
        mode_q    <= mode;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: two instances (IW=8 and IW=16) against a frame-position model.
module tb_video_pattern_gen;

  localparam int HT = 20;
  localparam int VT = 10;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  cv = 8'd0;
  logic        vs, dv, fs, vs16, dv16, fs16;
  logic [15:0] data, data16, fc, fc16;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .DW(8), .CH(2), .H_TOTAL(HT), .V_TOTAL(VT), .IW(8), .IH(4), .H_VLD_B(2),
    .V_VLD_B(5), .SYNC_B(1), .SYNC_E(2), .CW(5)
  ) u_dut (
    .clk(clk), .reset_l(rst), .en(en), .mode(mode), .const_val(cv),
    .test_vsync(vs), .test_dvalid(dv), .test_data(data), .frame_start(fs), .frame_cnt(fc)
  );

  video_pattern_gen #(
    .DW(8), .CH(2), .H_TOTAL(HT), .V_TOTAL(VT), .IW(16), .IH(4), .H_VLD_B(2),
    .V_VLD_B(5), .SYNC_B(1), .SYNC_E(2), .CW(5)
  ) u_dut16 (
    .clk(clk), .reset_l(rst), .en(en), .mode(mode), .const_val(cv),
    .test_vsync(vs16), .test_dvalid(dv16), .test_data(data16), .frame_start(fs16),
    .frame_cnt(fc16)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: a running flag plus linear position within the frame.
  bit          m_run = 0;
  int          m_pos = 0;
  int          m_mq = 0;
  logic [15:0] m_fc = 16'd0;
  logic        e_vs, e_dv, e_dv16, e_fs;
  logic [15:0] e_data, e_data16;

  // Frame statistics measured on the DUT outputs.
  int          st_vs, st_dv, st_dv16, fs_seen;
  bit          st_first_set;
  logic [15:0] st_first, st_last, st_chk16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y, input int m,
                                      input logic [7:0] c_val);
    logic [15:0] r;
    int t;
    for (int c = 0; c < 2; c++) begin
      case (m)
        0:       t = x + c;
        1:       t = y + c;
        2:       t = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 255 : 0;
        default: t = int'(c_val);
      endcase
      r[c*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    int h, v;
    bit act_v;
    if (rst) begin
      e_vs = 1'b1; e_dv = 1'b0; e_dv16 = 1'b0; e_fs = 1'b0;
      e_data = 16'd0; e_data16 = 16'd0;
      m_run = 0; m_pos = 0; m_mq = 0; m_fc = 16'd0;
    end else if (m_run) begin
      h = m_pos % HT;
      v = m_pos / HT;
      e_fs = (m_pos == 0);
      if (e_fs) begin
        m_mq = int'(mode);
        m_fc = m_fc + 16'd1;
      end
      e_vs     = !(v >= 1 && v <= 2);
      act_v    = (v >= 5 && v <= 8);
      e_dv     = act_v && h >= 2 && h < 2 + 8;
      e_dv16   = act_v && h >= 2 && h < 2 + 16;
      e_data   = e_dv   ? pix(h - 2, v - 5, m_mq, cv) : 16'd0;
      e_data16 = e_dv16 ? pix(h - 2, v - 5, m_mq, cv) : 16'd0;
      if (m_pos == FR - 1 && !en) begin
        m_run = 0;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FR;
      end
    end else begin
      e_vs = 1'b1; e_dv = 1'b0; e_dv16 = 1'b0; e_fs = 1'b0;
      e_data = 16'd0; e_data16 = 16'd0;
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("vsync", vs, e_vs);
    chk("dvalid", dv, e_dv);
    chk("data", data, e_data);
    chk("frame_start", fs, e_fs);
    chk("frame_cnt", fc, m_fc);
    chk("dvalid16", dv16, e_dv16);
    chk("data16", data16, e_data16);
    chk("frame_cnt16", fc16, m_fc);
    if (e_fs) begin
      st_vs = 0; st_dv = 0; st_dv16 = 0; st_first_set = 0;
    end
    if (fs) fs_seen++;
    if (!vs) st_vs++;
    if (dv) begin
      if (!st_first_set) begin
        st_first = data;
        st_first_set = 1;
      end
      st_last = data;
      st_dv++;
    end
    if (dv16) begin
      if (st_dv16 == 8) st_chk16 = data16;
      st_dv16++;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_vsync", vs, 1);
    chk("reset_dvalid", dv, 0);
    chk("reset_fc", fc, 0);

    rst = 1'b0; en = 1'b1; mode = 2'd0;
    tick();
    chk("fs_not_after_1", fs, 0);
    tick();
    chk("fs_latency_2", fs, 1);
    repeat (FR - 1) tick();
    chk("vsync_low_clocks", st_vs, 40);
    chk("dvalid_clocks", st_dv, 32);
    chk("dvalid16_clocks", st_dv16, 64);
    chk("ramp_first_pixel", st_first, 16'h0100);
    chk("ramp_last_pixel", st_last, 16'h0807);

    mode = 2'd2;
    repeat (FR) tick();
    chk("checker16_x8_y0", st_chk16, 16'hFFFF);
    chk("checker_first", st_first, 16'h0000);

    mode = 2'd3; cv = 8'hA5;
    repeat (FR) tick();
    chk("const_first", st_first, 16'hA5A5);
    chk("const_dvalid", st_dv, 32);

    mode = 2'd0;
    repeat (120) tick();
    mode = 2'd1;
    repeat (FR - 120) tick();
    chk("mode_held_last", st_last, 16'h0807);

    repeat (50) tick();
    en = 1'b0;
    repeat (FR - 50) tick();
    chk("mode1_last", st_last, 16'h0403);
    chk("stop_full_frame", st_dv, 32);
    fs_seen = 0;
    repeat (30) tick();
    chk("idle_no_fs", fs_seen, 0);
    chk("idle_fc_hold", fc, 5);
    chk("idle_vsync", vs, 1);

    en = 1'b1;
    tick();
    repeat (50) tick();
    en = 1'b0;
    repeat (50) tick();
    en = 1'b1;
    repeat (100) tick();
    tick();
    chk("no_gap_fs", fs, 1);
    chk("fc_after_restart", fc, 7);
    en = 1'b0;
    repeat (FR) tick();

    force u_dut.frame_cnt = 16'hFFFE;
    force u_dut16.frame_cnt = 16'hFFFE;
    #1;
    release u_dut.frame_cnt;
    release u_dut16.frame_cnt;
    m_fc = 16'hFFFE;
    en = 1'b1;
    tick();
    tick();
    chk("fc_ffff", fc, 16'hFFFF);
    repeat (FR - 1) tick();
    tick();
    chk("fc_wrap", fc, 16'h0000);
    chk("fc_wrap_fs", fs, 1);

    repeat (123) tick();
    chk("pre_reset_dvalid", dv, 1);
    rst = 1'b1;
    tick();
    chk("rst_dvalid", dv, 0);
    chk("rst_data", data, 0);
    chk("rst_vsync", vs, 1);
    chk("rst_fc", fc, 0);
    repeat (3) tick();
    chk("rst_hold_no_fs", fs, 0);
    rst = 1'b0;
    tick();
    chk("restart_fs_wait", fs, 0);
    tick();
    chk("restart_fs", fs, 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) en = ~en;
      mode = 2'($urandom_range(3));
      if (!m_run || m_pos == 0) cv = 8'($urandom);
      rst = ($urandom_range(799) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Parametrised synthesizable video stream source for the image-processing bench and on-board bring-up. It generates frame timing (active-low vsync, dvalid window) and a selectable test pattern over CH channels of DW bits each, with run/stop control that only stops on frame boundaries. It drives the same vsync/dvalid/data stream consumed by the downstream processing blocks. It replaces file-driven sources wherever a deterministic, self-checkable pattern is needed.

## Interface
- DW, 8: bits per channel
- CH, 1: channels per pixel (test_data width = DW*CH, channel c at bits [c*DW +: DW])
- H_TOTAL, 1440: clocks per line
- V_TOTAL, 600: lines per frame
- IW, 1280: active clocks per line
- IH, 513: active lines per frame
- H_VLD_B, 0: first active column
- V_VLD_B, 65: first active line
- SYNC_B, 5 / SYNC_E, 55: first/last line of vsync pulse (inclusive)
- CW, 11: h/v counter width; legality requirements are H_VLD_B+IW ≤ H_TOTAL, V_VLD_B+IH ≤ V_TOTAL, SYNC_B ≤ SYNC_E < V_TOTAL, and H_TOTAL, V_TOTAL ≤ 2^CW (other values are illegal, not checked)
- clk  in  1  single clock; all logic on rising edge
- reset_l  in  1  synchronous reset, **active-high** (the _l suffix is a historical name; 1 = reset)
- en  in  1  run request
- mode  in  2  pattern select, sampled only at frame start
- const_val  in  DW  value for constant mode
- test_vsync  out  1  frame sync, low during sync lines
- test_dvalid  out  1  pixel valid
- test_data  out  DW*CH  pixel data, 0 when test_dvalid=0
- frame_start  out  1  one-cycle pulse on first clock of each frame
- frame_cnt  out  16  frames started since reset, wraps

## Operation
- States: IDLE, RUN, STOP (finishing frame).
- IDLE: h_cnt=v_cnt=0 held; outputs at idle values. en=1 → RUN; first RUN cycle has h=v=0 (frame start).
- RUN: h_cnt increments, wraps at H_TOTAL-1 to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1. en=0 → STOP (counting continues).
- STOP: counting continues; en=1 → RUN with no gap; at h=H_TOTAL-1, v=V_TOTAL-1 with en=0 → IDLE. A frame is never truncated.
- Frame start = counting state with h=v=0: mode latched into mode_q, frame_cnt increments (0xFFFF→0), frame_start=1.
- vsync region: v in [SYNC_B, SYNC_E]; active: v in [V_VLD_B, V_VLD_B+IH-1] and h in [H_VLD_B, H_VLD_B+IW-1]; x=h-H_VLD_B, y=v-V_VLD_B.
- mode_q patterns, channel c, truncated to DW bits:
  - 0: horizontal ramp, x+c
  - 1: vertical ramp, y+c
  - 2: checker, all-ones if ((x>>3)^(y>>3))&1 else 0
  - 3: const_val on every channel

## Timing
- Reset values: state IDLE, h_cnt=v_cnt=0, mode_q=0, test_vsync=1, test_dvalid=0, test_data=0, frame_start=0, frame_cnt=0.
- Reset has priority over en in the same cycle; reset mid-frame aborts immediately, and all outputs take reset values on the next edge.
- All outputs are registered; outputs at edge t+1 reflect counter values at edge t (latency 1).
- en rise in IDLE at edge t: state RUN at t+1, frame_start=1 and first vsync/dvalid decode at t+2.
- mode/const_val changes mid-frame do not affect mode_q until the next frame start; const_val is used live, so it must be held stable by the user for the frame.
- In IDLE, test_vsync=1, test_dvalid=0, and frame_start stays 0.
- Exactly IW dvalid clocks per active line, IH active lines per frame, and SYNC_E-SYNC_B+1 vsync-low lines per frame.

## Test plan
Small params: H_TOTAL=20, V_TOTAL=10, IW=8, IH=4, H_VLD_B=2, V_VLD_B=5, SYNC_B=1, SYNC_E=2, DW=8, CH=2.
- Reset, then en=1 with mode=0 → frame_start 2 cycles after en; test_vsync low for exactly 40 clocks (lines 1-2); 32 dvalid clocks per frame; line data ch0 = 0..7, ch1 = 1..8.
- mode=2 and DW=8 with IW=16 → x=0..7 yields 0x00/0xFF by y parity and x=8..15 is inverted; mode=3 with const_val=0xA5 → data 0xA5A5 on all valid clocks, 0 otherwise.
- mode changed 0→1 mid-frame → current frame keeps ramp-x; next frame ch0 = y (0..3 per line).
- en dropped mid-frame → frame completes (all 4 active lines), IDLE after v=9,h=19, and frame_cnt stops; en re-raised during STOP → next frame follows with no idle cycles.
- frame_cnt preloaded to near-wrap via long run (or forced) → 0xFFFF→0x0000 on next frame_start.
- reset_l=1 asserted mid-active-line → next edge gives test_dvalid=0, test_data=0, test_vsync=1, frame_cnt=0, and state IDLE even with en=1 held; after release, a new frame starts from h=v=0.
